// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus
// the decode-side instruction handshake and redirect inputs.
interface fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr, instr_pc,
        input  instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr, instr_pc,
        output instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues in-order memory requests,
// buffers responses for decode and handles redirects by dropping stale returns.
module fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                INSTR_W   = 32,
    parameter int                BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    // fetch_pc is the address the next newly issued request will carry;
    // req_addr is the address currently presented (held until accepted).
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
    logic [ADDR_W-1:0] req_addr, req_addr_nxt;
    logic              req_valid, req_valid_nxt;
    logic              stale, stale_nxt;
    logic [CW-1:0]     os_cnt, os_nxt;
    logic [CW-1:0]     buf_cnt, buf_nxt;
    logic [CW-1:0]     drop_cnt, drop_nxt;
    logic [PW-1:0]     head, tail, pcq_rd, pcq_wr;
    entry_t            buf_mem [BUF_DEPTH];
    logic [ADDR_W-1:0] pcq [BUF_DEPTH];

    logic              accept, rsp, dropping, push, pop, hold, room;
    logic [ADDR_W-1:0] pc_src;

    assign accept   = req_valid & bus.imem_req_ready;
    // A response with nothing outstanding belongs to a pre-reset request.
    assign rsp      = bus.imem_rsp_valid & (os_cnt != '0);
    assign dropping = drop_cnt != '0;
    assign push     = rsp & ~dropping & ~bus.redirect;
    assign pop      = bus.instr_valid & bus.instr_ready;
    assign hold     = req_valid & ~bus.imem_req_ready;

    always_comb begin
        os_nxt    = os_cnt + CW'(accept) - CW'(rsp);
        buf_nxt   = buf_cnt + CW'(push) - CW'(pop);
        drop_nxt  = drop_cnt - CW'(rsp & dropping) + CW'(accept & stale);
        stale_nxt = stale & ~accept;
        pc_src    = fetch_pc;
        if (bus.redirect) begin
            buf_nxt   = '0;
            drop_nxt  = os_nxt;
            // an unaccepted request keeps its old address; drop it on accept
            stale_nxt = hold;
            pc_src    = bus.redirect_pc & ~ADDR_W'(3);
        end
        room          = ({1'b0, buf_nxt} + {1'b0, os_nxt}) < (CW+1)'(BUF_DEPTH);
        req_valid_nxt = hold | room;
        req_addr_nxt  = req_addr;
        fetch_pc_nxt  = pc_src;
        if (!hold && room) begin
            req_addr_nxt = pc_src;
            fetch_pc_nxt = pc_src + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_VEC;
            req_addr  <= RESET_VEC;
            req_valid <= 1'b0;
            stale     <= 1'b0;
            os_cnt    <= '0;
            buf_cnt   <= '0;
            drop_cnt  <= '0;
            head      <= '0;
            tail      <= '0;
            pcq_rd    <= '0;
            pcq_wr    <= '0;
        end else begin
            fetch_pc  <= fetch_pc_nxt;
            req_addr  <= req_addr_nxt;
            req_valid <= req_valid_nxt;
            stale     <= stale_nxt;
            os_cnt    <= os_nxt;
            buf_cnt   <= buf_nxt;
            drop_cnt  <= drop_nxt;
            if (accept) pcq_wr <= pcq_wr + PW'(1);
            if (rsp)    pcq_rd <= pcq_rd + PW'(1);
            if (push)   tail   <= tail + PW'(1);
            if (bus.redirect)
                head <= tail;
            else if (pop)
                head <= head + PW'(1);
        end
    end

    // PC queue is filled at accept and drained by every response, dropped or not.
    always_ff @(posedge clk) begin
        if (accept) pcq[pcq_wr] <= req_addr;
        if (push)   buf_mem[tail] <= '{instr: bus.imem_rsp_data, pc: pcq[pcq_rd]};
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = req_addr;
    assign bus.instr_valid    = buf_cnt != '0;
    assign bus.instr          = bus.instr_valid ? buf_mem[head].instr : '0;
    assign bus.instr_pc       = bus.instr_valid ? buf_mem[head].pc    : '0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, decode stall, stalled-request
// redirect, in-flight redirect, async reset and an 8-bit address wrap instance.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
    fetch_unit_if #(.ADDR_W(8),  .INSTR_W(32)) bus2 ();

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .BUF_DEPTH(2), .RESET_VEC(32'h0))
        dut (.clk(clk), .rst(rst), .bus(bus));
    fetch_unit #(.ADDR_W(8), .INSTR_W(32), .BUF_DEPTH(2), .RESET_VEC(8'hF8))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // memory model: fixed latency, in-order, data = addr ^ KEY
    typedef struct { logic [31:0] addr; int due; } inflight_t;
    inflight_t mq[$];
    int cyc = 0;
    int mem_lat = 1;
    int acc_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= '0;
            acc_cnt <= 0;
        end else begin
            cyc <= cyc + 1;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat - 1});
                acc_cnt <= acc_cnt + 1;
            end
            if (mq.size() > 0 && mq[0].due == cyc) begin
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= mq[0].addr ^ KEY;
                void'(mq.pop_front());
            end else begin
                bus.imem_rsp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        bus2.imem_rsp_valid <= !rst && bus2.imem_req_valid && bus2.imem_req_ready;
        bus2.imem_rsp_data  <= {24'h0, bus2.imem_req_addr};
    end

    logic [31:0] got_pc[$];
    logic [31:0] got_dat[$];
    logic [7:0]  w_addr[$];
    logic [7:0]  w_pc[$];

    always @(negedge clk) begin
        #1;
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            got_pc.push_back(bus.instr_pc);
            got_dat.push_back(bus.instr);
        end
        if (!rst && bus2.imem_req_valid && bus2.imem_req_ready && w_addr.size() < 4)
            w_addr.push_back(bus2.imem_req_addr);
        if (!rst && bus2.instr_valid && bus2.instr_ready && w_pc.size() < 4)
            w_pc.push_back(bus2.instr_pc);
    end

    task automatic do_reset(input int lat);
        rst = 1'b1;
        mem_lat = lat;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_pc.delete();
        got_dat.delete();
    endtask

    task automatic wait_got(input int n, input int budget, input string tag);
        int k = 0;
        while (got_pc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(got_pc.size() >= n), 64'd1);
    endtask

    task automatic chk_seq(input string tag, input logic [31:0] base, input int n);
        for (int i = 0; i < n && i < got_pc.size(); i++) begin
            chk($sformatf("%s_pc%0d", tag, i), got_pc[i], base + 32'(4 * i));
            chk($sformatf("%s_dat%0d", tag, i), got_dat[i], (base + 32'(4 * i)) ^ KEY);
        end
    endtask

    initial begin
        bus.imem_req_ready  = 1'b1;
        bus.instr_ready     = 1'b1;
        bus.redirect        = 1'b0;
        bus.redirect_pc     = '0;
        bus2.imem_req_ready = 1'b1;
        bus2.instr_ready    = 1'b1;
        bus2.redirect       = 1'b0;
        bus2.redirect_pc    = '0;

        // reset state and zero-wait streaming
        @(negedge clk);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_instr", bus.instr, 0);
        chk("rst_instr_pc", bus.instr_pc, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_req_valid", bus.imem_req_valid, 1);
        chk("first_req_addr", bus.imem_req_addr, 0);
        @(negedge clk);
        chk("ivalid_early", bus.instr_valid, 0);
        @(negedge clk);
        chk("ivalid_first", bus.instr_valid, 1);
        chk("ipc_first", bus.instr_pc, 0);
        wait_got(6, 60, "t1_count");
        chk_seq("t1", 32'h0, 6);

        // decode stall fills the buffer with exactly two entries
        bus.instr_ready = 1'b0;
        do_reset(1);
        repeat (10) @(negedge clk);
        chk("t2_accepts", acc_cnt, 2);
        chk("t2_req_valid", bus.imem_req_valid, 0);
        chk("t2_ivalid", bus.instr_valid, 1);
        chk("t2_head_pc", bus.instr_pc, 0);
        chk("t2_head_dat", bus.instr, KEY);
        got_pc.delete();
        got_dat.delete();
        bus.instr_ready = 1'b1;
        wait_got(4, 40, "t2_count");
        chk_seq("t2", 32'h0, 4);

        // asynchronous reset with a full buffer
        bus.instr_ready = 1'b0;
        do_reset(1);
        repeat (6) @(negedge clk);
        chk("t6_pre_full", bus.instr_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_ivalid", bus.instr_valid, 0);
        chk("t6_req_valid", bus.imem_req_valid, 0);
        chk("t6_instr_pc", bus.instr_pc, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_req_after", bus.imem_req_valid, 1);
        chk("t6_addr_after", bus.imem_req_addr, 0);

        // redirect while the first request is stalled
        bus.instr_ready    = 1'b1;
        bus.imem_req_ready = 1'b0;
        do_reset(1);
        repeat (2) @(negedge clk);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        @(negedge clk);
        bus.redirect = 1'b0;
        chk("t3_hold_valid", bus.imem_req_valid, 1);
        chk("t3_hold_addr", bus.imem_req_addr, 0);
        repeat (2) @(negedge clk);
        chk("t3_hold_addr2", bus.imem_req_addr, 0);
        bus.imem_req_ready = 1'b1;
        wait_got(2, 30, "t3_count");
        chk_seq("t3", 32'h100, 2);

        // redirect with two requests in flight (0x20, 0x24)
        begin
            int k = 0;
            bit hit = 0;
            do_reset(3);
            while (!hit && k < 300) begin
                @(negedge clk);
                k++;
                if (mq.size() == 2)
                    hit = (mq[0].addr == 32'h20) && (mq[1].addr == 32'h24);
            end
            chk("t4_inflight_seen", 64'(hit), 64'd1);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h403;
        @(negedge clk);
        bus.redirect = 1'b0;
        got_pc.delete();
        got_dat.delete();
        chk("t4_flush", bus.instr_valid, 0);
        wait_got(1, 60, "t4_count");
        chk_seq("t4", 32'h400, 1);

        // narrow-address instance wraps from F8 through 04
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = 8'hF8 + 8'(4 * i);
            chk($sformatf("t5_addr%0d", i), (i < w_addr.size()) ? w_addr[i] : 8'hxx, e);
            chk($sformatf("t5_pc%0d", i), (i < w_pc.size()) ? w_pc[i] : 8'hxx, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
